lsu_sequencer: RTL and testbench

- Load/store front end sitting directly upstream of the memory access unit.
- Accepts one load/store request from the execute stage and computes the effective address.
- Decodes RV32I funct3 into the memory unit's size/unsigned controls, runs the available/busy handshake, and returns load data or an exception to writeback.
- One request in flight at a time.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_sequencer_if.sv | 22 ++
 rtl/lsu_decode.sv | 35 +++
 rtl/lsu_sequencer.sv | 117 +++++++++++
 tb/tb_lsu_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer and its funct3 decoder.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RELEASE
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MEM_OP_BYTE = 2'b00;
  localparam logic [1:0] MEM_OP_HALF = 2'b01;
  localparam logic [1:0] MEM_OP_WORD = 2'b10;

  // Only the low address bits matter for natural alignment of byte/half/word.
  function automatic logic misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
    return ((op == MEM_OP_HALF) && addr_lo[0]) ||
           ((op == MEM_OP_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Memory access unit bus: sequencer (master) drives the request, memory unit (slave) responds.
interface lsu_sequencer_if;
  logic        mem_available;
  logic        mem_is_write;
  logic        mem_is_unsigned;
  logic [1:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic [31:0] mem_out;
  logic        mem_busy;
  logic        mem_fault;

  modport master (
    output mem_available, mem_is_write, mem_is_unsigned, mem_op, mem_addr, mem_in,
    input  mem_out, mem_busy, mem_fault
  );

  modport slave (
    input  mem_available, mem_is_write, mem_is_unsigned, mem_op, mem_addr, mem_in,
    output mem_out, mem_busy, mem_fault
  );
endinterface

// File: rtl/lsu_decode.sv
// RV32I load/store funct3 decode into memory unit size/sign controls plus an illegal flag.
module lsu_decode
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_store,
  output logic [1:0] op,
  output logic       is_unsigned,
  output logic       illegal
);

  always_comb begin
    op          = MEM_OP_BYTE;
    is_unsigned = 1'b0;
    illegal     = 1'b0;
    case (funct3)
      F3_B:  op = MEM_OP_BYTE;
      F3_H:  op = MEM_OP_HALF;
      F3_W:  op = MEM_OP_WORD;
      // Unsigned variants exist for loads only.
      F3_BU: begin
        op          = MEM_OP_BYTE;
        is_unsigned = ~is_store;
        illegal     = is_store;
      end
      F3_HU: begin
        op          = MEM_OP_HALF;
        is_unsigned = ~is_store;
        illegal     = is_store;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store front end: effective address, funct3 decode, memory handshake, writeback result.
// Define LSU_PRECHECK_EN to reject misaligned accesses in IDLE without touching memory.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned IMM_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [31:0]      base,
  input  logic [IMM_W-1:0] offset,
  input  logic [31:0]      store_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      load_data,
  output logic             exc_illegal,
  output logic             exc_misaligned,
  output logic [31:0]      exc_addr,
  lsu_sequencer_if.master  mem
);

  state_e      state_q;
  logic [31:0] addr_q, data_q, load_q, exc_addr_q;
  logic [1:0]  op_q;
  logic        store_q, uns_q, done_q, exc_ill_q, exc_mis_q;

  logic [1:0]  dec_op;
  logic        dec_uns, dec_illegal, pre_misaligned;
  logic [31:0] ea;

  lsu_decode u_decode (
    .funct3      (funct3),
    .is_store    (is_store),
    .op          (dec_op),
    .is_unsigned (dec_uns),
    .illegal     (dec_illegal)
  );

  assign ea = base + {{(32 - IMM_W){offset[IMM_W-1]}}, offset};

`ifdef LSU_PRECHECK_EN
  assign pre_misaligned = misaligned(dec_op, ea[1:0]);
`else
  assign pre_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      load_q     <= '0;
      exc_addr_q <= '0;
      op_q       <= MEM_OP_BYTE;
      store_q    <= 1'b0;
      uns_q      <= 1'b0;
      done_q     <= 1'b0;
      exc_ill_q  <= 1'b0;
      exc_mis_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= ea;
            data_q  <= store_data;
            store_q <= is_store;
            op_q    <= dec_op;
            uns_q   <= dec_uns;
            // Rejected requests complete immediately and never raise mem_available.
            if (dec_illegal || pre_misaligned) begin
              done_q     <= 1'b1;
              exc_ill_q  <= dec_illegal;
              exc_mis_q  <= ~dec_illegal;
              exc_addr_q <= ea;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          if (mem.mem_fault || !mem.mem_busy) begin
            done_q     <= 1'b1;
            exc_ill_q  <= 1'b0;
            exc_mis_q  <= mem.mem_fault;
            exc_addr_q <= addr_q;
            if (!mem.mem_fault && !store_q) load_q <= mem.mem_out;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (!mem.mem_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign load_data      = load_q;
  assign exc_illegal    = exc_ill_q;
  assign exc_misaligned = exc_mis_q;
  assign exc_addr       = exc_addr_q;

  assign mem.mem_available   = (state_q == REQ) || (state_q == WAIT);
  assign mem.mem_is_write    = store_q;
  assign mem.mem_is_unsigned = uns_q;
  assign mem.mem_op          = op_q;
  assign mem.mem_addr        = addr_q;
  assign mem.mem_in          = data_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer with a small latency-configurable memory unit model.
module tb_lsu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [11:0] offset;
  logic [31:0] store_data;
  logic        busy, done, exc_illegal, exc_misaligned;
  logic [31:0] load_data, exc_addr;

  lsu_sequencer_if bus ();

  lsu_sequencer #(.IMM_W(12)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .is_store       (is_store),
    .funct3         (funct3),
    .base           (base),
    .offset         (offset),
    .store_data     (store_data),
    .busy           (busy),
    .done           (done),
    .load_data      (load_data),
    .exc_illegal    (exc_illegal),
    .exc_misaligned (exc_misaligned),
    .exc_addr       (exc_addr),
    .mem            (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory unit model: on seeing available it goes busy for lat cycles, optionally faulting.
  int          lat;
  logic        fault_en;
  logic [31:0] rdata;
  logic        m_active, m_busy, m_fault;
  int          m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_busy   <= 1'b0;
      m_fault  <= 1'b0;
      m_cnt    <= 0;
    end else if (!m_active) begin
      if (bus.mem_available) begin
        m_active <= 1'b1;
        m_busy   <= 1'b1;
        m_fault  <= fault_en;
        m_cnt    <= lat;
      end
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy  <= 1'b0;
        m_fault <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (!bus.mem_available) begin
      m_active <= 1'b0;
    end
  end

  assign bus.mem_busy  = m_busy;
  assign bus.mem_fault = m_fault;
  assign bus.mem_out   = rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] b,
                     input logic [11:0] off, input logic [31:0] d);
    is_store   = st;
    funct3     = f3;
    base       = b;
    offset     = off;
    store_data = d;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    chk("idle_bound", 32'(busy), 32'd0);
  endtask

  int n;
  int ndone;
  int done_at;

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    base = '0; offset = '0; store_data = '0;
    lat = 1; fault_en = 1'b0; rdata = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_exc_addr", exc_addr, 32'd0);
    chk("rst_avail", 32'(bus.mem_available), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;

    // LW 0x1000+4, one busy cycle from memory
    rdata = 32'hDEADBEEF;
    req(1'b0, 3'b010, 32'h1000, 12'h004, 32'h0);
    chk("lw_busy", 32'(busy), 32'd1);
    chk("lw_avail_req", 32'(bus.mem_available), 32'd1);
    chk("lw_mem_addr", bus.mem_addr, 32'h1004);
    chk("lw_mem_op", 32'(bus.mem_op), 32'd2);
    chk("lw_mem_wr", 32'(bus.mem_is_write), 32'd0);
    tick();
    chk("lw_avail_wait", 32'(bus.mem_available), 32'd1);
    chk("lw_no_early_done", 32'(done), 32'd0);
    tick();
    wait_done(10, n);
    chk("lw_done_cycle", 32'(n + 2), 32'd3);
    chk("lw_load_data", load_data, 32'hDEADBEEF);
    chk("lw_exc_ill", 32'(exc_illegal), 32'd0);
    chk("lw_exc_mis", 32'(exc_misaligned), 32'd0);
    chk("lw_exc_addr", exc_addr, 32'h1004);
    chk("lw_avail_release", 32'(bus.mem_available), 32'd0);
    tick();
    chk("lw_done_pulse", 32'(done), 32'd0);
    chk("lw_busy_low", 32'(busy), 32'd0);

    // SB 0x20 + (-1)
    req(1'b1, 3'b000, 32'h20, 12'hFFF, 32'hA5);
    chk("sb_mem_addr", bus.mem_addr, 32'h1F);
    chk("sb_mem_wr", 32'(bus.mem_is_write), 32'd1);
    chk("sb_mem_op", 32'(bus.mem_op), 32'd0);
    chk("sb_mem_in", bus.mem_in, 32'hA5);
    wait_done(10, n);
    chk("sb_done_cycle", 32'(n), 32'd3);
    chk("sb_exc_ill", 32'(exc_illegal), 32'd0);
    chk("sb_exc_mis", 32'(exc_misaligned), 32'd0);
    chk("sb_load_data_kept", load_data, 32'hDEADBEEF);
    wait_idle(10);

    // Misaligned LH at 0x1001
    fault_en = 1'b1;
    lat = 4;
    req(1'b0, 3'b001, 32'h1000, 12'h001, 32'h0);
`ifdef LSU_PRECHECK_EN
    chk("mis_pre_done", 32'(done), 32'd1);
    chk("mis_pre_exc", 32'(exc_misaligned), 32'd1);
    chk("mis_pre_avail", 32'(bus.mem_available), 32'd0);
    chk("mis_pre_busy", 32'(busy), 32'd0);
    chk("mis_pre_addr", exc_addr, 32'h1001);
    tick();
    chk("mis_pre_avail2", 32'(bus.mem_available), 32'd0);
`else
    wait_done(10, n);
    chk("mis_done_cycle", 32'(n), 32'd2);
    chk("mis_exc", 32'(exc_misaligned), 32'd1);
    chk("mis_exc_ill", 32'(exc_illegal), 32'd0);
    chk("mis_addr", exc_addr, 32'h1001);
    chk("mis_load_kept", load_data, 32'hDEADBEEF);
    tick(); tick(); tick();
    chk("mis_release_hold", 32'(busy), 32'd1);
    tick();
    chk("mis_release_exit", 32'(busy), 32'd0);
`endif
    fault_en = 1'b0;
    lat = 1;

    // Illegal load funct3 and illegal store funct3
    req(1'b0, 3'b011, 32'h40, 12'h000, 32'h0);
    chk("ill_ld_done", 32'(done), 32'd1);
    chk("ill_ld_exc", 32'(exc_illegal), 32'd1);
    chk("ill_ld_mis", 32'(exc_misaligned), 32'd0);
    chk("ill_ld_avail", 32'(bus.mem_available), 32'd0);
    chk("ill_ld_busy", 32'(busy), 32'd0);
    chk("ill_ld_addr", exc_addr, 32'h40);
    tick();
    chk("ill_ld_pulse", 32'(done), 32'd0);
    req(1'b1, 3'b100, 32'h80, 12'h000, 32'h0);
    chk("ill_st_exc", 32'(exc_illegal), 32'd1);
    chk("ill_st_avail", 32'(bus.mem_available), 32'd0);
    tick();

    // Wait states with ignored start pulses
    lat = 5;
    rdata = 32'h12345678;
    req(1'b0, 3'b010, 32'h2000, 12'h000, 32'h0);
    ndone = 0;
    done_at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        done_at = i;
      end
      base  = 32'h5000;
      start = (i == 2 || i == 4);
    end
    start = 1'b0;
    chk("ws_done_count", 32'(ndone), 32'd1);
    chk("ws_done_cycle", 32'(done_at), 32'd7);
    chk("ws_load_data", load_data, 32'h12345678);
    chk("ws_no_requeue", 32'(busy), 32'd0);
    chk("ws_addr_kept", bus.mem_addr, 32'h2000);

    // Reset asserted while in WAIT
    req(1'b0, 3'b010, 32'h3000, 12'h000, 32'h0);
    tick(); tick();
    chk("rw_avail_wait", 32'(bus.mem_available), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_avail", 32'(bus.mem_available), 32'd0);
    chk("rw_load_data", load_data, 32'd0);
    chk("rw_exc_addr", exc_addr, 32'd0);
    #1 reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("rw_no_done", 32'(ndone), 32'd0);
    chk("rw_idle", 32'(busy), 32'd0);

    // Back-to-back LW then LBU with start held high
    lat = 1;
    rdata = 32'hCAFEF00D;
    req(1'b0, 3'b010, 32'h0, 12'h004, 32'h0);
    wait_done(10, n);
    chk("b2b_first_cycle", 32'(n), 32'd3);
    chk("b2b_first_data", load_data, 32'hCAFEF00D);
    rdata    = 32'h000000FF;
    funct3   = 3'b100;
    is_store = 1'b0;
    base     = 32'h0;
    offset   = 12'h003;
    start    = 1'b1;
    tick();
    chk("b2b_release_ignore", 32'(busy), 32'd0);
    chk("b2b_addr_kept", bus.mem_addr, 32'h4);
    tick();
    start = 1'b0;
    chk("b2b_accept", 32'(busy), 32'd1);
    chk("b2b_mem_addr", bus.mem_addr, 32'h3);
    chk("b2b_unsigned", 32'(bus.mem_is_unsigned), 32'd1);
    chk("b2b_mem_op", 32'(bus.mem_op), 32'd0);
    wait_done(10, n);
    chk("b2b_second_cycle", 32'(n), 32'd3);
    chk("b2b_load_data", load_data, 32'h000000FF);
    wait_idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
